// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO owner and multiply/divide sequencer for the EX stage.
// Optional macro HILO_BYPASS_EN: forward the value being written this cycle onto hi/lo.
module hilo_muldiv_ctrl #(
  parameter int MUL_LAT  = 1,
  parameter int DIV_ITER = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        stall,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;
  localparam logic [5:0] MUL_CNT  = 6'(MUL_LAT);
  localparam logic [5:0] DIV_CNT  = 6'(DIV_ITER);

  state_t      r_state;
  logic [5:0]  r_cnt;
  logic [31:0] r_hi, r_lo, r_a, r_b, r_quo, r_rem;
  logic        r_is_mul, r_signed, r_neg_q, r_neg_r, r_dz, r_div_zero;

  logic        w_op_mul, w_op_div, w_idle_req, w_accept, w_sdiv, w_commit, w_ge;
  logic [31:0] w_a_mag, w_b_mag, w_sub, w_quo_fix, w_rem_fix, w_res_hi, w_res_lo;
  logic [32:0] w_rem_sh;
  logic [63:0] w_ma, w_mb, w_prod;

  assign w_op_mul   = (op == OP_MULT) || (op == OP_MULTU);
  assign w_op_div   = (op == OP_DIV) || (op == OP_DIVU);
  assign w_idle_req = (r_state == S_IDLE) && start && !flush;
  assign w_accept   = w_idle_req && (w_op_mul || w_op_div);
  assign w_sdiv     = (op == OP_DIV);
  assign w_a_mag    = (w_sdiv && a[31]) ? -a : a;
  assign w_b_mag    = (w_sdiv && b[31]) ? -b : b;

  // Restoring step: the dividend shifts out of r_quo's top while quotient bits shift in at the bottom.
  assign w_rem_sh = {r_rem, r_quo[31]};
  assign w_ge     = w_rem_sh >= {1'b0, r_b};
  assign w_sub    = w_rem_sh[31:0] - r_b;

  // Sign-extending to 64 bits lets one unsigned multiplier serve both MULT and MULTU.
  assign w_ma   = {{32{r_signed & r_a[31]}}, r_a};
  assign w_mb   = {{32{r_signed & r_b[31]}}, r_b};
  assign w_prod = w_ma * w_mb;

  assign w_quo_fix = r_neg_q ? -r_quo : r_quo;
  assign w_rem_fix = r_neg_r ? -r_rem : r_rem;

  always_comb begin
    w_res_hi = w_rem_fix;
    w_res_lo = w_quo_fix;
    if (r_is_mul) begin
      w_res_hi = w_prod[63:32];
      w_res_lo = w_prod[31:0];
    end else if (r_dz) begin
      w_res_hi = r_a;
      w_res_lo = 32'hFFFF_FFFF;
    end
  end

  assign w_commit = (r_state == S_DONE) && !flush;
  assign stall    = ((r_state == S_IDLE) && start && (w_op_mul || w_op_div))
                    || (r_state == S_MUL) || (r_state == S_DIV);
  assign busy     = (r_state != S_IDLE);
  assign done     = w_commit;
  assign div_zero = r_div_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_quo      <= '0;
      r_rem      <= '0;
      r_is_mul   <= 1'b0;
      r_signed   <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_dz       <= 1'b0;
      r_div_zero <= 1'b0;
    end else if (flush) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && op == OP_MTHI) r_hi <= a;
          if (start && op == OP_MTLO) r_lo <= a;
          if (w_accept) begin
            r_div_zero <= 1'b0;
            r_a        <= a;
            if (w_op_mul) begin
              r_is_mul <= 1'b1;
              r_signed <= (op == OP_MULT);
              r_b      <= b;
              r_cnt    <= MUL_CNT;
              r_state  <= S_MUL;
            end else begin
              r_is_mul <= 1'b0;
              r_signed <= w_sdiv;
              r_b      <= w_b_mag;
              r_quo    <= w_a_mag;
              r_rem    <= '0;
              r_neg_q  <= w_sdiv && (a[31] ^ b[31]);
              r_neg_r  <= w_sdiv && a[31];
              r_dz     <= (b == 32'd0);
              if (b == 32'd0) begin
                r_cnt   <= '0;
                r_state <= S_DONE;
              end else begin
                r_cnt   <= DIV_CNT;
                r_state <= S_DIV;
              end
            end
          end
        end
        S_MUL: begin
          r_cnt <= r_cnt - 6'd1;
          if (r_cnt == 6'd1) r_state <= S_DONE;
        end
        S_DIV: begin
          r_cnt <= r_cnt - 6'd1;
          if (w_ge) begin
            r_rem <= w_sub;
            r_quo <= {r_quo[30:0], 1'b1};
          end else begin
            r_rem <= w_rem_sh[31:0];
            r_quo <= {r_quo[30:0], 1'b0};
          end
          if (r_cnt == 6'd1) r_state <= S_DONE;
        end
        S_DONE: begin
          r_hi    <= w_res_hi;
          r_lo    <= w_res_lo;
          if (!r_is_mul && r_dz) r_div_zero <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef HILO_BYPASS_EN
  always_comb begin
    hi = r_hi;
    lo = r_lo;
    if (w_commit) begin
      hi = w_res_hi;
      lo = w_res_lo;
    end else if (w_idle_req && op == OP_MTHI) begin
      hi = a;
    end else if (w_idle_req && op == OP_MTLO) begin
      lo = a;
    end
  end
`else
  assign hi = r_hi;
  assign lo = r_lo;
`endif

endmodule

// File: doc/hilo_muldiv_ctrl.md
Name: hilo_muldiv_ctrl

Overview:
Sequencer and owner of the HI/LO register pair for the EX stage.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests alongside the ALU.
- Runs a latency-configurable multiply and a 32-iteration restoring divide.
- Stalls the pipeline until the result commits, then presents HI/LO for MFHI/MFLO.
- Replaces the ALU-local hilo register as the single HI/LO source.

Parameters:
MUL_LAT, 1, multiply compute cycles between acceptance and DONE (1..8)
DIV_ITER, 32, divide iteration cycles; fixed at 32 for 32-bit operands

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset; asynchronous, active-low
start  in  1  EX-stage request valid
op  in  3  000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 reserved (treated as none)
a  in  32  rs operand (dividend / multiplicand / MTHI/MTLO source)
b  in  32  rt operand (divisor / multiplier)
flush  in  1  abort in-flight operation (exception or branch squash)
stall  out  1  hold EX and earlier stages
busy  out  1  state != IDLE
done  out  1  one-cycle pulse in the cycle HI/LO commit from MUL/DIV
div_zero  out  1  sticky; set by divide with b==0, cleared by next accepted MUL/DIV
hi  out  32  HI register
lo  out  32  LO register

Behaviour:
- Reset (rst_n low, async): state=IDLE, hi=0, lo=0, stall=0, busy=0, done=0, div_zero=0, counter=0. Reset mid-operation discards the operation.
- States: IDLE, MUL, DIV, DONE.
- IDLE, start with MTHI/MTLO: hi or lo <= a at this edge. No stall, no state change.
- IDLE, start with MUL/DIV op: operands and sign info are latched. stall=1 combinationally in this same cycle.
  - MULT/MULTU -> MUL with counter=MUL_LAT.
  - DIV/DIVU -> DIV with counter=DIV_ITER.
- MUL: 64-bit product is computed signed (MULT) or unsigned (MULTU). Counter decrements each cycle; at counter==1 the state goes to DONE.
- DIV: operates on magnitudes |a| and |b|; DIVU uses raw values. One restoring step per cycle: shift the remainder left, shift in the next dividend bit, subtract if no borrow, set the quotient bit. After DIV_ITER steps the state goes to DONE.
- Signed divide fixup (applied in DONE):
  - Quotient is negated if a[31]^b[31].
  - Remainder is negated if a[31].
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- Divide by zero (b==0): iterations are skipped and the state goes from the accept cycle directly to DONE. Committed values are lo=0xFFFFFFFF and hi=a. div_zero is set.
- DONE:
  - lo<=low word (quotient), hi<=high word (remainder) at the end of the cycle.
  - done=1 and stall=0 in this cycle; the next state is IDLE.
  - MFHI/MFLO in the following EX cycle see the new values.
- stall = (IDLE & start & op in MUL/DIV set) | state==MUL | state==DIV.
- Latency:
  - MUL: stall high for 1+MUL_LAT cycles, then DONE.
  - DIV: stall high for 33 cycles, then DONE.
- Priority: flush > everything except reset.
  - Flush in MUL/DIV/DONE: state goes to IDLE, hi/lo are unchanged, and no done pulse is produced.
  - Flush in IDLE with start: the request is ignored, including MTHI/MTLO.
- start while not IDLE is ignored. The upstream stages are frozen by stall, so the request is re-presented in DONE/IDLE. start in DONE is not accepted; it is accepted in the following IDLE cycle.

Optional Feature:
Macro HILO_BYPASS_EN.
- Defined: hi/lo outputs are muxed combinationally to show the value being written in the current cycle. This covers an MTHI/MTLO write and a DONE commit, so a same-cycle consumer sees the new value. Registered state is identical.
- Undefined: hi/lo are pure register outputs. New values appear the cycle after the write.

Test Plan:
- MULT a=0xFFFFFFFF b=0x00000002, MUL_LAT=1 -> stall high 2 cycles, done pulse, then hi=0xFFFFFFFF lo=0xFFFFFFFE. MULTU with the same operands -> hi=0x00000001 lo=0xFFFFFFFE.
- DIVU a=100 b=7 -> stall high 33 cycles, done on cycle 34, lo=0x0000000E hi=0x00000002. DIV a=-7 b=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF. DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000 hi=0.
- DIV a=0x12345678 b=0 -> done 2 cycles after accept, lo=0xFFFFFFFF hi=0x12345678, div_zero=1. A following MULTU 3*4 -> div_zero clears, lo=12 hi=0.
- MTHI a=0xAAAA5555, then MTLO a=0x1234 in back-to-back cycles -> no stall, hi=0xAAAA5555 lo=0x00001234.
- Preload hi=1 lo=2, start DIVU, assert flush at iteration 10 -> state IDLE next cycle, no done, hi=1 lo=2 unchanged.
- Preload hi=1 lo=2, start DIVU, drop rst_n at iteration 5 -> all outputs 0 asynchronously. After release, MULTU 5*5 gives lo=25.
- With HILO_BYPASS_EN: MTLO a=0x77 -> lo output reads 0x77 in the same cycle.
